// File: rtl/fifo_pkg.sv
// Shared FIFO defaults and the packed status word used by sync_fifo_param.
package fifo_pkg;
    localparam int FIFO_DATA_W_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;
endpackage

// File: rtl/sync_fifo_param_if.sv
// FIFO request/response bundle; slave = FIFO side, master = producer/consumer side.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    logic [DATA_W-1:0]        data_in;
    logic                     w_en;
    logic                     r_en;
    logic [DATA_W-1:0]        data_out;
    logic                     rd_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport slave (
        input  data_in, w_en, r_en,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport master (
        output data_in, w_en, r_en,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port (1-cycle latency).
// Only the read register is reset; the array keeps whatever it held.
module fifo_sdp_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_dat,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_dat
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    // Output holds between reads so the consumer sees the last popped word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO: registered read (1-edge latency), full rejects writes, empty rejects reads.
// Define SYNC_FIFO_ERR_FLAGS_EN to get sticky overflow/underflow flags; otherwise they read 0.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = FIFO_DATA_W_DEF,
    parameter int DEPTH     = FIFO_DEPTH_DEF,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    sync_fifo_param_if.slave  fif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_rd_valid;
    logic          w_wr_acc;
    logic          w_rd_acc;
    fifo_status_t  w_status;

    always_comb begin
        w_status.full         = (r_count == CW'(DEPTH));
        w_status.empty        = (r_count == '0);
        w_status.almost_full  = (r_count >= CW'(AF_THRESH));
        w_status.almost_empty = (r_count <= CW'(AE_THRESH));
    end

    // Acceptance is judged on the pre-edge count, so full+both reads only and empty+both writes only.
    assign w_wr_acc = fif.w_en && !w_status.full;
    assign w_rd_acc = fif.r_en && !w_status.empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (fif.data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (fif.data_out)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (fif.w_en && w_status.full) begin
                r_overflow <= 1'b1;
            end
            if (fif.r_en && w_status.empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign fif.overflow  = r_overflow;
    assign fif.underflow = r_underflow;
`else
    assign fif.overflow  = 1'b0;
    assign fif.underflow = 1'b0;
`endif

    assign fif.rd_valid     = r_rd_valid;
    assign fif.count        = r_count;
    assign fif.full         = w_status.full;
    assign fif.empty        = w_status.empty;
    assign fif.almost_full  = w_status.almost_full;
    assign fif.almost_empty = w_status.almost_empty;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at DATA_W=8, DEPTH=16, AF=14, AE=2.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) dif ();

    sync_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];    // contents of the modelled FIFO
    logic [DW-1:0] exp_q[$];  // words expected on data_out, in order
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_unf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status();
        int n;
        n = m_q.size();
        chk("count",        64'(dif.count),        64'(n));
        chk("full",         64'(dif.full),         64'(n == DEPTH));
        chk("empty",        64'(dif.empty),        64'(n == 0));
        chk("almost_full",  64'(dif.almost_full),  64'(n >= AF));
        chk("almost_empty", 64'(dif.almost_empty), 64'(n <= AE));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow",     64'(dif.overflow),     64'(m_ovf));
        chk("underflow",    64'(dif.underflow),    64'(m_unf));
`else
        chk("overflow",     64'(dif.overflow),     64'(0));
        chk("underflow",    64'(dif.underflow),    64'(0));
`endif
    endtask

    // One clock: drive request, update model with pre-edge occupancy, then check outputs.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] din);
        logic wa;
        logic ra;
        logic [DW-1:0] got;
        wa = we && (m_q.size() < DEPTH);
        ra = re && (m_q.size() > 0);
        if (we && !wa) m_ovf = 1'b1;
        if (re && !ra) m_unf = 1'b1;
        if (ra) exp_q.push_back(m_q.pop_front());
        if (wa) m_q.push_back(din);
        dif.data_in = din;
        dif.w_en    = we;
        dif.r_en    = re;
        @(posedge clk);
        #1;
        dif.w_en = 1'b0;
        dif.r_en = 1'b0;
        chk("rd_valid", 64'(dif.rd_valid), 64'(ra));
        if (dif.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_read", 64'(dif.data_out), 64'hDEAD);
            end else begin
                got    = exp_q.pop_front();
                m_dout = got;
                chk("data_out", 64'(dif.data_out), 64'(got));
            end
        end else begin
            chk("data_hold", 64'(dif.data_out), 64'(m_dout));
        end
        chk_status();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && m_q.size() > 0; i++) step(1'b0, 1'b1, 8'h00);
    endtask

    task automatic model_reset();
        m_q.delete();
        exp_q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    initial begin
        dif.data_in = '0;
        dif.w_en    = 1'b0;
        dif.r_en    = 1'b0;
        model_reset();

        // Reset state, observed while reset is held.
        #2;
        chk("rst_data_out", 64'(dif.data_out), 64'h0);
        chk("rst_rd_valid", 64'(dif.rd_valid), 64'h0);
        chk_status();
        @(negedge clk);
        rst = 1'b0;

        // Fill 0x01..0x10 then drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

        // Overflow attempt: 0xAA must never appear.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b0, 8'hAA);
        drain();

        // Underflow attempt, then write+read on empty.
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b1, 8'h33);
        chk("empty_both_count", 64'(dif.count), 64'd1);
        drain();

        // Occupancy 8 streaming across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'(8'h80 + i));
        chk("stream_count", 64'(dif.count), 64'd8);
        drain();

        // Full with write+read: only the read happens.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
        step(1'b1, 1'b1, 8'hEE);
        chk("full_both_count", 64'(dif.count), 64'd15);
        drain();

        // Asynchronous reset between edges at occupancy 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        step(1'b0, 1'b1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_count",    64'(dif.count),    64'd0);
        chk("arst_empty",    64'(dif.empty),    64'd1);
        chk("arst_data_out", 64'(dif.data_out), 64'h0);
        chk("arst_rd_valid", 64'(dif.rd_valid), 64'h0);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 8'h5A);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        if (exp_q.size() != 0) chk("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end
endmodule
